// File: rtl/demux_pkg.sv
// demux_pkg: shared widths, state type and word type
// for the serial-to-parallel bit loader.
package demux_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 5;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } ld_state_t;

  localparam word_t ALL_ONES = '1;

endpackage

// File: rtl/dec5to32.sv
// dec5to32: combinational one-hot decoder with enable,
// forms the per-bit write enables of the loader.
module dec5to32
  import demux_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output word_t            onehot
);

  // one bit set at sel when enabled, else all zero
  always_comb begin
    onehot = '0;
    if (en) onehot = word_t'(1) << sel;
  end

endmodule

// File: rtl/demux1to32_reg.sv
// demux1to32_reg: bit-serial loader into a 32-bit word with
// valid/take handoff. DEMUX_PARITY_EN adds a PARITY output.
module demux1to32_reg
  import demux_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN,
  input  logic [SEL_W-1:0] SEL,
  input  logic             WR,
  input  logic             CLR,
  input  logic             TAKE,
  output logic [WORD_W-1:0] WORD_OUT,
  output logic [WORD_W-1:0] MASK,
  output logic             VALID,
  output logic             OVERRUN
`ifdef DEMUX_PARITY_EN
  ,
  output logic             PARITY
`endif
);

  ld_state_t state_q, state_d;
  word_t     word_q, word_d;
  word_t     mask_q, mask_d;
  logic      ovr_q, ovr_d;
  word_t     wen;
  word_t     din;

  dec5to32 u_dec (
    .en     (WR),
    .sel    (SEL),
    .onehot (wen)
  );

  assign din = wen & {WORD_W{IN}};

  // state register
  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= FILL;
    else          state_q <= state_d;
  end

  // next state: fill completes on all-ones mask, take retires
  always_comb begin
    state_d = state_q;
    if (CLR) begin
      state_d = FILL;
    end else begin
      unique case (state_q)
        FILL: if ((mask_q | wen) == ALL_ONES)
                state_d = HOLD;
        HOLD: if (TAKE) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // datapath next values: merge, retire-and-restart, or drop
  always_comb begin
    word_d = word_q;
    mask_d = mask_q;
    ovr_d  = 1'b0;
    if (CLR) begin
      word_d = '0;
      mask_d = '0;
    end else begin
      unique case (1'b1)
        (state_q == FILL): begin
          word_d = (word_q & ~wen) | din;
          mask_d = mask_q | wen;
        end
        (state_q == HOLD && TAKE): begin
          word_d = din;
          mask_d = wen;
        end
        (state_q == HOLD && !TAKE && WR): begin
          ovr_d = 1'b1;
        end
        default: begin
          ovr_d = 1'b0;
        end
      endcase
    end
  end

  // output registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      word_q <= '0;
      mask_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
      ovr_q  <= ovr_d;
    end
  end

  assign WORD_OUT = word_q;
  assign MASK     = mask_q;
  assign VALID    = (state_q == HOLD);
  assign OVERRUN  = ovr_q;

`ifdef DEMUX_PARITY_EN
  logic par_q;

  // even parity of the word being stored this edge
  always_ff @(posedge CLK) begin
    if (!RESET_N) par_q <= 1'b0;
    else          par_q <= ^word_d;
  end

  assign PARITY = par_q;
`endif

endmodule

// File: tb/tb_demux1to32_reg.sv
// tb_demux1to32_reg: table vectors, directed corner
// sequences and random stimulus against a bit-array model.
module tb_demux1to32_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_i;
  logic [4:0]  sel;
  logic        wr;
  logic        clr;
  logic        take;
  logic [31:0] word_out;
  logic [31:0] mask;
  logic        valid;
  logic        overrun;
`ifdef DEMUX_PARITY_EN
  logic        parity;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  bit m_word [32];
  bit m_mask [32];
  bit m_hold;
  bit m_ovr;

  demux1to32_reg dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .IN       (in_i),
    .SEL      (sel),
    .WR       (wr),
    .CLR      (clr),
    .TAKE     (take),
    .WORD_OUT (word_out),
    .MASK     (mask),
    .VALID    (valid),
    .OVERRUN  (overrun)
`ifdef DEMUX_PARITY_EN
    ,
    .PARITY   (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input bit a [32]);
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic int popc(input bit a [32]);
    int n = 0;
    for (int i = 0; i < 32; i++) n += a[i];
    return n;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m_word[i] = 1'b0;
      m_mask[i] = 1'b0;
    end
  endtask

  task automatic model(input logic r, input logic i,
                       input logic [4:0] s,
                       input logic w, input logic c,
                       input logic t);
    if (!r || c) begin
      clear_model();
      m_hold = 0;
      m_ovr  = 0;
    end else if (!m_hold) begin
      m_ovr = 0;
      if (w) begin
        m_word[s] = i;
        m_mask[s] = 1'b1;
      end
      if (popc(m_mask) == 32) m_hold = 1;
    end else if (t) begin
      clear_model();
      m_hold = 0;
      m_ovr  = 0;
      if (w) begin
        m_word[s] = i;
        m_mask[s] = 1'b1;
      end
    end else begin
      m_ovr = w;
    end
  endtask

  task automatic step(input logic r, input logic i,
                      input logic [4:0] s,
                      input logic w, input logic c,
                      input logic t);
    logic [31:0] ew;
    rst_n = r; in_i = i; sel = s;
    wr = w; clr = c; take = t;
    @(posedge clk);
    #1;
    model(r, i, s, w, c, t);
    ew = pack(m_word);
    chk("mdl_word", word_out, ew);
    chk("mdl_mask", mask, pack(m_mask));
    chk("mdl_valid", 32'(valid), 32'(m_hold));
    chk("mdl_ovr", 32'(overrun), 32'(m_ovr));
`ifdef DEMUX_PARITY_EN
    chk("mdl_par", 32'(parity), 32'(^ew));
`endif
  endtask

  task automatic wrb(input logic [4:0] s, input logic i);
    step(1, i, s, 1, 0, 0);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        r, i, w, c, t;
    logic [4:0]  s;
    logic [31:0] ew, em;
    logic        ev, eo;
  } vec_t;

  vec_t tbl [8];

  initial begin
    rst_n = 0; in_i = 0; sel = 0;
    wr = 0; clr = 0; take = 0;
    clear_model();
    m_hold = 0;
    m_ovr  = 0;

    step(0, 0, 0, 0, 0, 0);
    chk("rst_word", word_out, 32'h0);
    chk("rst_mask", mask, 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);

    tbl[0] = '{1,1,1,0,0, 5, 32'h20, 32'h20, 0, 0};
    tbl[1] = '{1,0,1,0,0, 5, 32'h00, 32'h20, 0, 0};
    tbl[2] = '{1,0,0,0,1, 0, 32'h00, 32'h20, 0, 0};
    tbl[3] = '{1,1,1,0,0, 0, 32'h01, 32'h21, 0, 0};
    tbl[4] = '{1,1,1,1,0, 7, 32'h00, 32'h00, 0, 0};
    tbl[5] = '{1,1,1,0,0, 31, 32'h80000000,
               32'h80000000, 0, 0};
    tbl[6] = '{0,1,1,0,0, 2, 32'h0, 32'h0, 0, 0};
    tbl[7] = '{1,1,0,0,0, 3, 32'h0, 32'h0, 0, 0};
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].r, tbl[k].i, tbl[k].s,
           tbl[k].w, tbl[k].c, tbl[k].t);
      chk($sformatf("tbl%0d_word", k), word_out, tbl[k].ew);
      chk($sformatf("tbl%0d_mask", k), mask, tbl[k].em);
      chk($sformatf("tbl%0d_valid", k),
          32'(valid), 32'(tbl[k].ev));
      chk($sformatf("tbl%0d_ovr", k),
          32'(overrun), 32'(tbl[k].eo));
    end

    for (int k = 0; k < 10; k++) wrb(5'(k), 1'b1);
    step(0, 1, 3, 1, 0, 1);
    chk("midrst_word", word_out, 32'h0);
    chk("midrst_mask", mask, 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);

    for (int k = 0; k < 32; k++) begin
      wrb(5'(k), k[0]);
      if (k == 30)
        chk("fill31_valid", 32'(valid), 32'h0);
    end
    chk("fill_word", word_out, 32'hAAAAAAAA);
    chk("fill_mask", mask, 32'hFFFFFFFF);
    chk("fill_valid", 32'(valid), 32'h1);
`ifdef DEMUX_PARITY_EN
    chk("fill_par", 32'(parity), 32'h0);
`endif

    wrb(3, 0);
    chk("ovr_word", word_out, 32'hAAAAAAAA);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    idle();
    chk("ovr_drop", 32'(overrun), 32'h0);
    chk("ovr_valid", 32'(valid), 32'h1);
    wrb(1, 0);
    wrb(2, 1);
    chk("ovr_b2b", 32'(overrun), 32'h1);

    step(1, 1, 31, 1, 0, 1);
    chk("tw_word", word_out, 32'h80000000);
    chk("tw_mask", mask, 32'h80000000);
    chk("tw_valid", 32'(valid), 32'h0);
    chk("tw_ovr", 32'(overrun), 32'h0);

    step(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 32; k++) wrb(5'(31 - k), 1'b1);
    chk("ff_valid", 32'(valid), 32'h1);
    step(1, 0, 0, 0, 0, 1);
    chk("take_word", word_out, 32'h0);
    chk("take_mask", mask, 32'h0);
    chk("take_valid", 32'(valid), 32'h0);

    for (int k = 0; k < 20; k++) wrb(5'(k), 1'b1);
    step(1, 1, 25, 1, 1, 0);
    chk("clr_word", word_out, 32'h0);
    chk("clr_mask", mask, 32'h0);

    for (int k = 0; k < 3000; k++) begin
      logic r, i, w, c, t;
      r = ($urandom_range(0, 199) != 0);
      c = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 5) == 0);
      i = 1'($urandom);
      step(r, i, 5'($urandom), w, c, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1to32_reg.md
# demux1to32_reg

Serial-to-parallel bit loader for the register-file datapath: accepts one data bit per write strobe and stores it at the 5-bit-addressed position of a 32-bit holding register, inverting the bit-select operation of the 32:1 read mux. Tracks which positions have been written and presents the completed word to a downstream consumer under a valid/take handshake. Sits between a bit-serial source (scan or debug loader) and any 32-bit word sink.

## Interface
- No parameters; width fixed at 32 bits, select at 5 bits (constants in package).
- CLK  input  1  system clock, all state updates on rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- IN  input  1  data bit to store.
- SEL  input  5  target bit position, 0..31.
- WR  input  1  write strobe; IN stored at SEL when accepted.
- CLR  input  1  synchronous flush of word and mask.
- TAKE  input  1  consumer accepts WORD_OUT; meaningful only while VALID=1.
- WORD_OUT  output  32  assembled word.
- MASK  output  32  bit i = 1 once position i has been written in the current word.
- VALID  output  1  all 32 positions written; word stable.
- OVERRUN  output  1  one-cycle pulse when a write is dropped.
- PARITY  output  1  present only with DEMUX_PARITY_EN.

## Operation
- States: FILL, HOLD.
- Reset (RESET_N=0 at edge): state=FILL, WORD_OUT=0, MASK=0, VALID=0, OVERRUN=0, PARITY=0. Reset overrides all other inputs, including mid-fill.
- FILL, WR=1: WORD_OUT[SEL] <= IN, MASK[SEL] <= 1. Re-write of an already-set position overwrites the data bit; MASK is unchanged.
- FILL -> HOLD when the post-update MASK equals all ones. VALID=1 in HOLD.
- HOLD, WR=1, TAKE=0: write dropped, WORD_OUT and MASK unchanged, OVERRUN pulses.
- HOLD, TAKE=1, WR=0: WORD_OUT <= 0, MASK <= 0, state -> FILL.
- HOLD, TAKE=1, WR=1: word retired and write applied to a fresh word: WORD_OUT <= IN<<SEL, MASK <= 1<<SEL, state -> FILL, no OVERRUN.
- TAKE while in FILL: ignored.
- CLR=1 (priority below reset, above WR/TAKE): WORD_OUT=0, MASK=0, state -> FILL, OVERRUN=0; any simultaneous WR is discarded.
- Bit-position decode is one-hot from SEL; no out-of-range case exists.

## Timing
- All outputs registered; WR/SEL/IN sampled at edge N, visible on WORD_OUT/MASK after edge N.
- VALID rises in the cycle following the edge that accepted the 32nd distinct position; minimum fill = 32 cycles.
- TAKE handshake: word consumed at the edge where VALID=1 and TAKE=1; VALID low the following cycle unless the same-edge write completes a word (impossible; one bit cannot fill 32).
- OVERRUN high exactly one cycle after the dropping edge; back-to-back drops hold it high.
- Throughput: one word per 32 cycles with overlapped TAKE/WR.

## Configuration
- DEMUX_PARITY_EN defined: PARITY output exists; registered even parity (XOR-reduce) of the next WORD_OUT value, updated on the same edge as WORD_OUT; 0 at reset/CLR/TAKE-clear.
- Undefined: no PARITY port, no parity logic; all other behaviour identical.

## Structure
- Package demux_pkg: WORD_W=32, SEL_W=5, typedef enum logic {FILL, HOLD} ld_state_t, typedef logic [WORD_W-1:0] word_t.
- One sub-module: dec5to32 — combinational 5-to-32 one-hot decoder with enable, used to form bit write enables; top instantiates it once.

## Test plan
- Reset mid-fill: write 10 bits, assert RESET_N=0 one edge -> WORD_OUT=0, MASK=0, VALID=0, state FILL.
- Sequential fill: SEL=0..31, IN=SEL[0] -> after 32nd edge WORD_OUT=32'hAAAAAAAA, MASK=32'hFFFFFFFF, VALID=1; PARITY=0 when enabled.
- Overwrite: write SEL=5 IN=1 then SEL=5 IN=0 -> WORD_OUT[5]=0, MASK=32'h00000020, still FILL.
- Overrun: full word, hold TAKE=0, WR=1 SEL=3 IN=0 -> word unchanged, OVERRUN=1 for one cycle.
- Simultaneous TAKE+WR in HOLD with SEL=31 IN=1 -> WORD_OUT=32'h80000000, MASK=32'h80000000, VALID=0, no OVERRUN.
- CLR with WR at same edge after 20 writes -> WORD_OUT=0, MASK=0, write discarded.
